dc_pred_decoder: RTL and testbench
==================================

DC_PRED_DECODER -- requirements
Module: dc_pred_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default `CH (3): number of colour-component predictors.
REQ-002 SHALL have parameter COEF_W, default 12: signed coefficient width.
REQ-003 SHALL have parameter BLK_LEN, default 64: coefficients per 8x8 block.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on posedge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: upstream coefficient valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a coefficient this cycle.
REQ-008 SHALL have port in_value, input, COEF_W signed: DC difference or AC coefficient.
REQ-009 SHALL have port in_ch, input, $clog2(NUM_CH+1): component index, sampled only on DC.
REQ-010 SHALL have port restart, input, 1: single-cycle RSTn-marker pulse.
REQ-011 SHALL have port out_valid, output, 1: output coefficient valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts.
REQ-013 SHALL have port out_value, output, COEF_W signed: reconstructed coefficient.
REQ-014 SHALL have port out_ch, output, $clog2(NUM_CH+1): component of the current block.
REQ-015 SHALL have port out_dc, output, 1: out_value is a block's DC term.
REQ-016 SHALL have port out_last, output, 1: out_value is coefficient BLK_LEN-1.
REQ-017 SHALL have ports err_ch, sat, output, 1 each: sticky out-of-range-channel and saturation flags.

Function
REQ-018 SHALL accept a coefficient when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-019 SHALL keep a coefficient counter idx (0..BLK_LEN-1), increment per accepted coefficient, wrap BLK_LEN-1 -> 0.
REQ-020 SHALL treat idx==0 as DC: latch in_ch as block channel; out = sat(in_value + pred[ch]); pred[ch] <= out.
REQ-021 SHALL pass AC (idx!=0) through unchanged; out_ch = latched block channel.
REQ-022 SHALL form sum at COEF_W+1 bits, clamp to [-2^(COEF_W-1), 2^(COEF_W-1)-1], set sat on any clamp.
REQ-023 SHALL register output: accepted coefficient appears on out_* exactly 1 cycle after handshake; back-to-back throughput 1/cycle when out_ready=1.
REQ-024 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-025 SHALL, on DC with in_ch >= NUM_CH: out_value = in_value, no predictor update, set err_ch; block still counted.
REQ-026 SHALL, on restart, clear all predictors to 0 and idx to 0 at the next edge; out register unaffected.
REQ-027 SHALL, on restart coincident with a handshake: process that coefficient with pre-restart pred/idx, then restart state overrides its updates.
REQ-028 SHALL, on restart mid-block (idx!=0), abandon the block; next accepted coefficient is DC.
REQ-029 SHALL keep err_ch and sat set until rst.

Reset
REQ-030 SHALL on rst: pred[*]=0, idx=0, latched ch=0, out_valid=0, out_value=0, out_ch=0, out_dc=0, out_last=0, err_ch=0, sat=0.
REQ-031 SHALL give rst priority over restart and handshakes in the same cycle.

Structure
REQ-032 SHALL take `CH and BLK_LEN default (64) from sys_defs.svh; no module-local copies.
REQ-033 SHALL put the widen-add-clamp in one sub-module dc_sat_add (parameter COEF_W; outputs sum, clamped flag).
REQ-034 SHALL store predictors as a NUM_CH x COEF_W register array, one write port.

Verification
REQ-035 SHALL test: ch0 DC diffs 5, -3, 10 over three 64-coef blocks -> DC outputs 5, 2, 12; AC unchanged; out_last on every 64th.
REQ-036 SHALL test: interleave ch0/ch1/ch2 blocks, DC diffs 100/200/-50 twice -> DC 100,200,-50 then 200,400,-100.
REQ-037 SHALL test: pred=2040, diff +20 -> out 2047, sat=1; pred=-2040, diff -20 -> -2048.
REQ-038 SHALL test: restart after idx=10 of a ch0 block with pred=7, then DC diff 4 -> out 4, out_dc=1.
REQ-039 SHALL test: out_ready low 5 cycles with stream pending -> out_* stable, in_ready=0, no loss/duplication vs model.
REQ-040 SHALL test: DC with in_ch=3 (NUM_CH=3), diff 9 -> out 9, err_ch=1, preds unchanged.

Source files
------------

// File: rtl/dc_pred_decoder_pkg.sv
// Shared constants and types for the DC prediction decoder.
`include "sys_defs.svh"

package dc_pred_decoder_pkg;
  localparam int DEF_NUM_CH  = `CH;
  localparam int DEF_BLK_LEN = `BLK_LEN;

  typedef enum logic {
    COEF_AC = 1'b0,
    COEF_DC = 1'b1
  } coef_kind_e;
endpackage

// File: rtl/dc_sat_add.sv
// Widening signed add with clamp to the COEF_W signed range.
module dc_sat_add #(
  parameter int COEF_W = 12
) (
  input  logic signed [COEF_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [COEF_W-1:0] sum,
  output logic                     clamped
);
  logic signed [COEF_W:0] wide;

  always_comb begin
    wide    = {a[COEF_W-1], a} + {b[COEF_W-1], b};
    sum     = wide[COEF_W-1:0];
    clamped = 1'b0;
    // Top two bits disagree only when the result left the narrow range.
    if (wide[COEF_W] != wide[COEF_W-1]) begin
      clamped = 1'b1;
      if (wide[COEF_W]) sum = {1'b1, {(COEF_W-1){1'b0}}};
      else              sum = {1'b0, {(COEF_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/sys_defs.svh
// System-wide defaults shared by the decoder blocks.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define CH 3
`define BLK_LEN 64
`endif

// File: rtl/dc_pred_decoder.sv
// Per-component DC prediction: DC diffs are accumulated into a predictor, AC passes through.
// Handshake: a beat moves when valid && ready; in_ready = !out_valid || out_ready; out_* hold while stalled.
module dc_pred_decoder
  import dc_pred_decoder_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int COEF_W  = 12,
  parameter int BLK_LEN = DEF_BLK_LEN,
  localparam int CH_W   = $clog2(NUM_CH + 1),
  localparam int IDX_W  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_value,
  input  logic [CH_W-1:0]          in_ch,
  input  logic                     restart,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_value,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_dc,
  output logic                     out_last,
  output logic                     err_ch,
  output logic                     sat
);
  localparam logic [CH_W-1:0]  NUM_CH_L = CH_W'(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

  logic signed [COEF_W-1:0] pred_q [NUM_CH];
  logic signed [COEF_W-1:0] pred_d [NUM_CH];
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [COEF_W-1:0] out_value_q, out_value_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic                     out_dc_q, out_dc_d;
  logic                     out_last_q, out_last_d;
  logic                     err_ch_q, err_ch_d;
  logic                     sat_q, sat_d;

  logic                     accept;
  coef_kind_e               kind;
  logic                     ch_ok;
  logic signed [COEF_W-1:0] pred_rd;
  logic signed [COEF_W-1:0] dc_sum;
  logic                     dc_clamped;
  logic                     pred_we;
  logic [CH_W-1:0]          pred_wa;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign kind      = (idx_q == '0) ? COEF_DC : COEF_AC;
  assign ch_ok     = in_ch < NUM_CH_L;

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_ch    = out_ch_q;
  assign out_dc    = out_dc_q;
  assign out_last  = out_last_q;
  assign err_ch    = err_ch_q;
  assign sat       = sat_q;

  always_comb begin
    pred_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_ch == CH_W'(i)) pred_rd = pred_q[i];
    end
  end

  dc_sat_add #(.COEF_W(COEF_W)) u_sat_add (
    .a       (in_value),
    .b       (pred_rd),
    .sum     (dc_sum),
    .clamped (dc_clamped)
  );

  always_comb begin
    idx_d       = idx_q;
    ch_d        = ch_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_ch_d    = out_ch_q;
    out_dc_d    = out_dc_q;
    out_last_d  = out_last_q;
    err_ch_d    = err_ch_q;
    sat_d       = sat_q;
    pred_we     = 1'b0;
    pred_wa     = in_ch;

    if (accept) begin
      out_valid_d = 1'b1;
      out_last_d  = (idx_q == LAST_IDX);
      idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      out_value_d = in_value;
      if (kind == COEF_DC) begin
        ch_d     = in_ch;
        out_ch_d = in_ch;
        out_dc_d = 1'b1;
        if (ch_ok) begin
          out_value_d = dc_sum;
          pred_we     = 1'b1;
          sat_d       = sat_q | dc_clamped;
        end else begin
          err_ch_d = 1'b1;
        end
      end else begin
        out_ch_d = ch_q;
        out_dc_d = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Restart wins over whatever the coincident beat did to idx and predictors.
    if (restart) idx_d = '0;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pred_d[i] = pred_q[i];
      if (restart)                             pred_d[i] = '0;
      else if (pred_we && pred_wa == CH_W'(i)) pred_d[i] = dc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) pred_q[i] <= '0;
      idx_q       <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_ch_q    <= '0;
      out_dc_q    <= 1'b0;
      out_last_q  <= 1'b0;
      err_ch_q    <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) pred_q[i] <= pred_d[i];
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_ch_q    <= out_ch_d;
      out_dc_q    <= out_dc_d;
      out_last_q  <= out_last_d;
      err_ch_q    <= err_ch_d;
      sat_q       <= sat_d;
    end
  end
endmodule

// File: tb/tb_dc_pred_decoder.sv
// Directed bench for dc_pred_decoder: block sequencing, prediction, clamping, restart, stall, bad channel.
module tb_dc_pred_decoder;
  localparam int COEF_W = 12;
  localparam int CH_W   = 2;

  logic                     clk;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] in_value;
  logic [CH_W-1:0]          in_ch;
  logic                     restart;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [COEF_W-1:0] out_value;
  logic [CH_W-1:0]          out_ch;
  logic                     out_dc;
  logic                     out_last;
  logic                     err_ch;
  logic                     sat;

  int total = 0;
  int bad   = 0;

  dc_pred_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_ch     (in_ch),
    .restart   (restart),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_ch    (out_ch),
    .out_dc    (out_dc),
    .out_last  (out_last),
    .err_ch    (err_ch),
    .sat       (sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one beat, let the edge take it, then settle 1ns past the edge.
  task automatic push(input int v, input int ch, input bit rs);
    in_valid = 1'b1;
    in_value = COEF_W'(v);
    in_ch    = CH_W'(ch);
    restart  = rs;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  // Full 64-coefficient block; AC values are a fixed ramp offset by channel.
  task automatic send_block(input int ch, input int diff, input int exp_dc);
    logic signed [COEF_W-1:0] exp_v;
    for (int k = 0; k < 64; k++) begin
      exp_v = (k == 0) ? COEF_W'(exp_dc) : COEF_W'(k * 3 - 90 + ch);
      push((k == 0) ? diff : (k * 3 - 90 + ch), ch, 1'b0);
      total++;
      if (out_valid !== 1'b1) begin
        bad++; $display("FAIL blk_valid ch=%0d k=%0d got=%b exp=1", ch, k, out_valid);
      end
      total++;
      if (out_value !== exp_v) begin
        bad++; $display("FAIL blk_value ch=%0d k=%0d got=%0d exp=%0d", ch, k, out_value, exp_v);
      end
      total++;
      if (out_dc !== (k == 0)) begin
        bad++; $display("FAIL blk_dc ch=%0d k=%0d got=%b", ch, k, out_dc);
      end
      total++;
      if (out_last !== (k == 63)) begin
        bad++; $display("FAIL blk_last ch=%0d k=%0d got=%b", ch, k, out_last);
      end
      total++;
      if (out_ch !== CH_W'(ch)) begin
        bad++; $display("FAIL blk_ch k=%0d got=%0d exp=%0d", k, out_ch, ch);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_value = '0; in_ch = '0; restart = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({out_valid, out_dc, out_last, err_ch, sat} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {out_valid, out_dc, out_last, err_ch, sat});
    end
    total++;
    if (out_value !== 12'sd0 || out_ch !== 2'd0) begin
      bad++; $display("FAIL reset_data value=%0d ch=%0d exp=0/0", out_value, out_ch);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_ch0_blocks();
    send_block(0, 5, 5);
    send_block(0, -3, 2);
    send_block(0, 10, 12);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL idle_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_interleave();
    pulse_restart();
    send_block(0, 100, 100);
    send_block(1, 200, 200);
    send_block(2, -50, -50);
    send_block(0, 100, 200);
    send_block(1, 200, 400);
    send_block(2, -50, -100);
  endtask

  task automatic test_saturation();
    pulse_restart();
    send_block(0, 2040, 2040);
    total++;
    if (sat !== 1'b0) begin
      bad++; $display("FAIL sat_early got=%b exp=0", sat);
    end
    send_block(0, 20, 2047);
    total++;
    if (sat !== 1'b1) begin
      bad++; $display("FAIL sat_pos got=%b exp=1", sat);
    end
    send_block(1, -2040, -2040);
    send_block(1, -20, -2048);
    total++;
    if (sat !== 1'b1) begin
      bad++; $display("FAIL sat_sticky got=%b exp=1", sat);
    end
  endtask

  task automatic test_restart_mid();
    pulse_restart();
    push(7, 0, 1'b0);
    total++;
    if (out_value !== 12'sd7 || out_dc !== 1'b1) begin
      bad++; $display("FAIL rst_mid_dc7 value=%0d dc=%b exp=7/1", out_value, out_dc);
    end
    for (int k = 1; k <= 10; k++) push(k, 0, 1'b0);
    pulse_restart();
    push(4, 0, 1'b0);
    total++;
    if (out_value !== 12'sd4 || out_dc !== 1'b1 || out_ch !== 2'd0) begin
      bad++; $display("FAIL rst_mid_dc4 value=%0d dc=%b ch=%0d exp=4/1/0", out_value, out_dc, out_ch);
    end
    // Beat coincident with restart is handled with the old idx (AC), then state clears.
    push(33, 0, 1'b1);
    total++;
    if (out_value !== 12'sd33 || out_dc !== 1'b0) begin
      bad++; $display("FAIL rst_coinc value=%0d dc=%b exp=33/0", out_value, out_dc);
    end
    push(6, 0, 1'b0);
    total++;
    if (out_value !== 12'sd6 || out_dc !== 1'b1) begin
      bad++; $display("FAIL rst_after_coinc value=%0d dc=%b exp=6/1", out_value, out_dc);
    end
  endtask

  task automatic test_stall();
    pulse_restart();
    out_ready = 1'b0;
    in_valid = 1'b1; in_value = 12'sd11; in_ch = 2'd1;
    @(posedge clk); #1;
    in_value = 12'sd22;
    total++;
    if (out_valid !== 1'b1 || out_value !== 12'sd11 || in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_first valid=%b value=%0d rdy=%b exp=1/11/0", out_valid, out_value, in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_value !== 12'sd11 || out_dc !== 1'b1 || out_ch !== 2'd1 || out_last !== 1'b0) begin
        bad++; $display("FAIL stall_hold c=%0d value=%0d dc=%b ch=%0d exp=11/1/1", c, out_value, out_dc, out_ch);
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_value !== 12'sd22 || out_dc !== 1'b0 || out_ch !== 2'd1) begin
      bad++; $display("FAIL stall_resume value=%0d dc=%b ch=%0d exp=22/0/1", out_value, out_dc, out_ch);
    end
    in_value = 12'sd23;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_value !== 12'sd23 || out_valid !== 1'b1) begin
      bad++; $display("FAIL stall_next value=%0d valid=%b exp=23/1", out_value, out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_drain valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_bad_channel();
    pulse_restart();
    total++;
    if (err_ch !== 1'b0) begin
      bad++; $display("FAIL err_pre got=%b exp=0", err_ch);
    end
    send_block(2, 5, 5);
    send_block(3, 9, 9);
    total++;
    if (err_ch !== 1'b1) begin
      bad++; $display("FAIL err_set got=%b exp=1", err_ch);
    end
    send_block(2, 1, 6);
    send_block(0, 0, 0);
    total++;
    if (err_ch !== 1'b1) begin
      bad++; $display("FAIL err_sticky got=%b exp=1", err_ch);
    end
  endtask

  task automatic test_rst_priority();
    rst = 1'b1; restart = 1'b1; in_valid = 1'b1; in_value = 12'sd50; in_ch = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0; restart = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, err_ch, sat} !== 3'b000 || out_value !== 12'sd0) begin
      bad++; $display("FAIL rst_prio valid/err/sat=%b value=%0d exp=000/0", {out_valid, err_ch, sat}, out_value);
    end
    push(3, 0, 1'b0);
    total++;
    if (out_value !== 12'sd3 || out_dc !== 1'b1) begin
      bad++; $display("FAIL rst_clears_pred value=%0d dc=%b exp=3/1", out_value, out_dc);
    end
  endtask

  initial begin
    test_reset();
    test_ch0_blocks();
    test_interleave();
    test_saturation();
    test_restart_mid();
    test_stall();
    test_bad_channel();
    test_rst_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
